amp_pwr_seq: RTL and testbench

Amplifier power sequencer and soft-mute controller between the EQ engine and the PDM speaker driver. It owns `sht_dwn`. It holds the amplifiers in shutdown until the low-frequency queues report full (`seq_low`), then:
- releases shutdown;
- waits a settle period;
- ramps audio gain from zero to unity over 256 samples.

On an amplifier fault (`Flt_n` low) it forces shutdown and mute, retries after a timeout, and locks out after repeated faults.

---
 rtl/amp_pwr_seq.sv | 206 ++++++++++++++++++++
 tb/tb_amp_pwr_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/amp_pwr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : amp_pwr_seq
//  Description : Amplifier power sequencer and soft-mute controller. Holds the
//                amplifiers in shutdown until the EQ queues are full, releases
//                shutdown, waits a settle period, then ramps gain from 0 to
//                unity over 256 samples. Faults force shutdown/mute, retry
//                after a timeout and lock out after repeated faults.
//  Revision    : 1.0 - initial release
// ============================================================================
module amp_pwr_seq #(
    parameter int SETTLE_CYC = 50000,
    parameter int RETRY_CYC  = 5000000,
    parameter int MAX_FAULTS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seq_low,
    input  logic        Flt_n,
    input  logic        vld,
    input  logic [15:0] aud_in_lft,
    input  logic [15:0] aud_in_rght,
    output logic [15:0] aud_out_lft,
    output logic [15:0] aud_out_rght,
    output logic        sht_dwn,
    output logic        lockout,
    output logic [3:0]  fault_cnt,
    output logic [2:0]  amp_state
);

    localparam int TMR_MAX = (SETTLE_CYC > RETRY_CYC) ? SETTLE_CYC : RETRY_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] c_SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] c_RETRY_LD  = TMR_W'(RETRY_CYC - 1);
    localparam logic [3:0]       c_MAX_FLT   = 4'(MAX_FAULTS);

    localparam logic [2:0] c_ST_WAIT_SEQ = 3'd0;
    localparam logic [2:0] c_ST_SETTLE   = 3'd1;
    localparam logic [2:0] c_ST_RAMP     = 3'd2;
    localparam logic [2:0] c_ST_RUN      = 3'd3;
    localparam logic [2:0] c_ST_FAULT    = 3'd4;
    localparam logic [2:0] c_ST_LOCKOUT  = 3'd5;

    logic             r_flt_meta;
    logic             r_flt_sync;
    logic             w_flt;

    logic [2:0]       r_state;
    logic [TMR_W-1:0] r_timer;
    logic [3:0]       r_fault_cnt;
    logic [8:0]       r_gain;
    logic             r_sht_dwn;
    logic             r_lockout;
    logic [15:0]      r_out_lft;
    logic [15:0]      r_out_rght;

    logic [2:0]       w_next_state;
    logic [TMR_W-1:0] w_next_timer;
    logic [3:0]       w_next_cnt;
    logic [8:0]       w_next_gain;
    logic [3:0]       w_cnt_inc;
    logic             w_cur_audible;
    logic             w_next_audible;

    logic signed [25:0] w_prod_lft;
    logic signed [25:0] w_prod_rght;
    logic               w_unused_prod;

    // Two-flop synchronizer for the asynchronous fault pin; resets to no-fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flt_meta <= 1'b1;
            r_flt_sync <= 1'b1;
        end else begin
            r_flt_meta <= Flt_n;
            r_flt_sync <= r_flt_meta;
        end
    end

    assign w_flt     = ~r_flt_sync;
    assign w_cnt_inc = (r_fault_cnt == 4'd15) ? 4'd15 : r_fault_cnt + 4'd1;

    // Next-state, timer, fault count and gain; fault entry overrides everything
    always_comb begin
        w_next_state = r_state;
        w_next_timer = r_timer;
        w_next_cnt   = r_fault_cnt;
        w_next_gain  = r_gain;

        case (r_state)
            c_ST_WAIT_SEQ: begin
                if (seq_low && !w_flt) begin
                    w_next_state = c_ST_SETTLE;
                    w_next_timer = c_SETTLE_LD;
                end
            end
            c_ST_SETTLE: begin
                if (r_timer == '0) begin
                    w_next_state = c_ST_RAMP;
                end else begin
                    w_next_timer = r_timer - 1'b1;
                end
            end
            c_ST_RAMP: begin
                if (vld) begin
                    w_next_gain = r_gain + 9'd1;
                    if (r_gain == 9'd255) begin
                        w_next_state = c_ST_RUN;
                    end
                end
            end
            c_ST_RUN: begin
                w_next_state = c_ST_RUN;
            end
            c_ST_FAULT: begin
                if (r_timer == '0) begin
                    if (w_flt) begin
                        w_next_timer = c_RETRY_LD;
                    end else begin
                        w_next_state = c_ST_SETTLE;
                        w_next_timer = c_SETTLE_LD;
                    end
                end else begin
                    w_next_timer = r_timer - 1'b1;
                end
            end
            c_ST_LOCKOUT: begin
                w_next_state = c_ST_LOCKOUT;
            end
            default: begin
                w_next_state = c_ST_WAIT_SEQ;
            end
        endcase

        // A fault while powered up is counted and mutes immediately
        if (w_flt && (r_state == c_ST_SETTLE || r_state == c_ST_RAMP ||
                      r_state == c_ST_RUN)) begin
            w_next_cnt = w_cnt_inc;
            if (w_cnt_inc >= c_MAX_FLT) begin
                w_next_state = c_ST_LOCKOUT;
            end else begin
                w_next_state = c_ST_FAULT;
                w_next_timer = c_RETRY_LD;
            end
        end

        // Gain only survives while the ramp or run is continuing
        if (w_next_state != c_ST_RAMP && w_next_state != c_ST_RUN) begin
            w_next_gain = 9'd0;
        end
    end

    assign w_cur_audible  = (r_state == c_ST_RAMP) || (r_state == c_ST_RUN);
    assign w_next_audible = (w_next_state == c_ST_RAMP) || (w_next_state == c_ST_RUN);

    // Gain is at most 256, so bits [23:8] never overflow
    assign w_prod_lft    = $signed(aud_in_lft)  * $signed({1'b0, r_gain});
    assign w_prod_rght   = $signed(aud_in_rght) * $signed({1'b0, r_gain});
    assign w_unused_prod = ^{w_prod_lft[25:24], w_prod_lft[7:0],
                             w_prod_rght[25:24], w_prod_rght[7:0]};

    // Control state registers; shutdown/lockout decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_WAIT_SEQ;
            r_timer     <= '0;
            r_fault_cnt <= 4'd0;
            r_gain      <= 9'd0;
            r_sht_dwn   <= 1'b1;
            r_lockout   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_timer     <= w_next_timer;
            r_fault_cnt <= w_next_cnt;
            r_gain      <= w_next_gain;
            r_sht_dwn   <= (w_next_state == c_ST_WAIT_SEQ) ||
                           (w_next_state == c_ST_FAULT)    ||
                           (w_next_state == c_ST_LOCKOUT);
            r_lockout   <= (w_next_state == c_ST_LOCKOUT);
        end
    end

    // Gained audio: muted every clock when not audible, else updated on vld
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_lft  <= 16'd0;
            r_out_rght <= 16'd0;
        end else if (!w_cur_audible || !w_next_audible) begin
            r_out_lft  <= 16'd0;
            r_out_rght <= 16'd0;
        end else if (vld) begin
            r_out_lft  <= w_prod_lft[23:8];
            r_out_rght <= w_prod_rght[23:8];
        end
    end

    assign aud_out_lft  = r_out_lft;
    assign aud_out_rght = r_out_rght;
    assign sht_dwn      = r_sht_dwn;
    assign lockout      = r_lockout;
    assign fault_cnt    = r_fault_cnt;
    assign amp_state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_amp_pwr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_amp_pwr_seq
//  Description : Directed self-checking bench for amp_pwr_seq with short
//                settle/retry timers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_amp_pwr_seq;

    logic        clk;
    logic        rst_n;
    logic        seq_low;
    logic        Flt_n;
    logic        vld;
    logic [15:0] aud_in_lft;
    logic [15:0] aud_in_rght;
    logic [15:0] aud_out_lft;
    logic [15:0] aud_out_rght;
    logic        sht_dwn;
    logic        lockout;
    logic [3:0]  fault_cnt;
    logic [2:0]  amp_state;

    int n_total;
    int n_bad;

    amp_pwr_seq #(
        .SETTLE_CYC (8),
        .RETRY_CYC  (16),
        .MAX_FAULTS (3)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seq_low      (seq_low),
        .Flt_n        (Flt_n),
        .vld          (vld),
        .aud_in_lft   (aud_in_lft),
        .aud_in_rght  (aud_in_rght),
        .aud_out_lft  (aud_out_lft),
        .aud_out_rght (aud_out_rght),
        .sht_dwn      (sht_dwn),
        .lockout      (lockout),
        .fault_cnt    (fault_cnt),
        .amp_state    (amp_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; returns 1 time unit after the rising edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle vld strobe followed by three idle cycles
    task automatic send_vld();
        vld = 1'b1;
        tick(1);
        vld = 1'b0;
        tick(3);
    endtask

    task automatic chk_muted(input string tag);
        chk({tag, "_shdn"}, {31'd0, sht_dwn}, 32'd1);
        chk({tag, "_outl"}, {16'd0, aud_out_lft}, 32'd0);
        chk({tag, "_outr"}, {16'd0, aud_out_rght}, 32'd0);
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        seq_low     = 1'b0;
        Flt_n       = 1'b1;
        vld         = 1'b0;
        aud_in_lft  = 16'h4000;
        aud_in_rght = 16'hC000;

        // Reset values
        #12;
        chk("rst_state", {29'd0, amp_state}, 32'd0);
        chk_muted("rst");
        chk("rst_cnt", {28'd0, fault_cnt}, 32'd0);
        chk("rst_lock", {31'd0, lockout}, 32'd0);

        // Power-up: queues not ready for 100 cycles
        tick(1);
        rst_n = 1'b1;
        tick(100);
        chk("wait_state", {29'd0, amp_state}, 32'd0);
        chk_muted("wait");

        // seq_low rises: shutdown released on the next edge, RAMP 8 cycles later
        seq_low = 1'b1;
        tick(1);
        chk("settle_shdn", {31'd0, sht_dwn}, 32'd0);
        chk("settle_state", {29'd0, amp_state}, 32'd1);
        seq_low = 1'b0;
        tick(7);
        chk("settle_7", {29'd0, amp_state}, 32'd1);
        tick(1);
        chk("ramp_entry", {29'd0, amp_state}, 32'd2);

        // Ramp over 256 strobes
        for (int i = 1; i <= 256; i++) begin
            send_vld();
            if (i == 1) begin
                chk("ramp1_l", {16'd0, aud_out_lft}, 32'h0000);
                chk("ramp1_r", {16'd0, aud_out_rght}, 32'h0000);
            end
            if (i == 129) begin
                chk("ramp129_l", {16'd0, aud_out_lft}, 32'h2000);
                chk("ramp129_r", {16'd0, aud_out_rght}, 32'hE000);
            end
            if (i == 255) chk("ramp255_state", {29'd0, amp_state}, 32'd2);
            if (i == 256) begin
                chk("ramp256_l", {16'd0, aud_out_lft}, 32'h3FC0);
                chk("ramp256_r", {16'd0, aud_out_rght}, 32'hC040);
                chk("run_state", {29'd0, amp_state}, 32'd3);
            end
        end
        send_vld();
        chk("run_l", {16'd0, aud_out_lft}, 32'h4000);
        chk("run_r", {16'd0, aud_out_rght}, 32'hC000);

        // Fault in RUN: 3-cycle low pulse, muted two edges after first sample
        Flt_n = 1'b0;
        tick(2);
        chk("flt_lat_state", {29'd0, amp_state}, 32'd3);
        chk("flt_lat_shdn", {31'd0, sht_dwn}, 32'd0);
        tick(1);
        Flt_n = 1'b1;
        chk("flt1_state", {29'd0, amp_state}, 32'd4);
        chk_muted("flt1");
        chk("flt1_cnt", {28'd0, fault_cnt}, 32'd1);
        tick(15);
        chk("flt1_hold", {29'd0, amp_state}, 32'd4);
        tick(1);
        chk("retry_state", {29'd0, amp_state}, 32'd1);
        chk("retry_shdn", {31'd0, sht_dwn}, 32'd0);
        tick(8);
        chk("retry_ramp", {29'd0, amp_state}, 32'd2);
        send_vld();
        chk("reramp0_l", {16'd0, aud_out_lft}, 32'h0000);
        send_vld();
        chk("reramp1_l", {16'd0, aud_out_lft}, 32'h0040);
        chk("reramp1_r", {16'd0, aud_out_rght}, 32'hFFC0);

        // Persistent fault: timer reloads, count unchanged
        Flt_n = 1'b0;
        tick(3);
        chk("flt2_state", {29'd0, amp_state}, 32'd4);
        chk("flt2_cnt", {28'd0, fault_cnt}, 32'd2);
        tick(16);
        chk("persist_state", {29'd0, amp_state}, 32'd4);
        chk("persist_cnt", {28'd0, fault_cnt}, 32'd2);
        Flt_n = 1'b1;
        tick(15);
        chk("persist_hold", {29'd0, amp_state}, 32'd4);
        tick(1);
        chk("persist_exit", {29'd0, amp_state}, 32'd1);
        tick(8);
        chk("persist_ramp", {29'd0, amp_state}, 32'd2);

        // Third fault: lockout, immune to seq_low and a clean fault pin
        Flt_n = 1'b0;
        tick(3);
        Flt_n   = 1'b1;
        seq_low = 1'b1;
        chk("lock_state", {29'd0, amp_state}, 32'd5);
        chk("lock_flag", {31'd0, lockout}, 32'd1);
        chk("lock_cnt", {28'd0, fault_cnt}, 32'd3);
        tick(40);
        chk("lock_hold", {29'd0, amp_state}, 32'd5);
        chk_muted("lock");

        // Asynchronous reset mid-operation
        rst_n   = 1'b0;
        seq_low = 1'b0;
        Flt_n   = 1'b0;
        #1;
        chk("arst_state", {29'd0, amp_state}, 32'd0);
        chk("arst_cnt", {28'd0, fault_cnt}, 32'd0);
        chk("arst_lock", {31'd0, lockout}, 32'd0);
        chk("arst_shdn", {31'd0, sht_dwn}, 32'd1);

        // Priority: fault in WAIT_SEQ blocks start-up and is not counted
        tick(1);
        rst_n = 1'b1;
        tick(3);
        seq_low = 1'b1;
        tick(5);
        chk("pri_wait_state", {29'd0, amp_state}, 32'd0);
        chk("pri_wait_cnt", {28'd0, fault_cnt}, 32'd0);
        Flt_n = 1'b1;
        tick(2);
        chk("pri_sync_state", {29'd0, amp_state}, 32'd0);
        tick(1);
        chk("pri_start", {29'd0, amp_state}, 32'd1);
        seq_low = 1'b0;
        tick(8);
        chk("pri_ramp", {29'd0, amp_state}, 32'd2);
        for (int i = 1; i <= 255; i++) send_vld();
        chk("pri_255_state", {29'd0, amp_state}, 32'd2);

        // Fault coincides with the final ramp strobe: FAULT wins over RUN
        Flt_n = 1'b0;
        tick(2);
        vld = 1'b1;
        tick(1);
        vld = 1'b0;
        chk("pri_last_state", {29'd0, amp_state}, 32'd4);
        chk("pri_last_cnt", {28'd0, fault_cnt}, 32'd1);
        chk_muted("pri_last");
        Flt_n = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
